// File: rtl/count16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count16_pkg
// Description : Shared widths, defaults and FSM encoding for count16_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package count16_pkg;

    localparam int c_CW_DEF          = 4;
    localparam int c_READ_CYCLES_DEF = 2;
    localparam int c_RDWIN_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_READ = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage : count16_pkg
`default_nettype wire

// File: rtl/count16_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : count16_seq_if
// Description : Host command/status bundle for the count16 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface count16_seq_if
    import count16_pkg::*;
#(
    parameter int CW = c_CW_DEF
);
    logic          start;
    logic [CW-1:0] start_val;
    logic [CW-1:0] end_val;
    logic          pause;
    logic          abort;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps;

    modport master (
        output start, start_val, end_val, pause, abort,
        input  busy, done, steps
    );

    modport slave (
        input  start, start_val, end_val, pause, abort,
        output busy, done, steps
    );
endinterface : count16_seq_if
`default_nettype wire

// File: rtl/count16_seq_rdwin.sv
`default_nettype none
// ============================================================================
// Module      : count16_seq_rdwin
// Description : Down-counter timing the read window; flags zero when expired.
// Revision    : 1.0 - initial release
// ============================================================================
module count16_seq_rdwin #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output logic                  zero
);
    logic [WIDTH-1:0] r_cnt_q;
    logic [WIDTH-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clr) begin
            w_cnt_d = '0;
        end else if (load) begin
            w_cnt_d = load_val;
        end else if (dec && (r_cnt_q != '0)) begin
            w_cnt_d = r_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign zero = (r_cnt_q == '0);

endmodule : count16_seq_rdwin
`default_nettype wire

// File: rtl/count16_seq.sv
`default_nettype none
// ============================================================================
// Module      : count16_seq
// Description : Drives a count16 through load / count / read-out on request.
// Revision    : 1.0 - initial release
// ============================================================================
module count16_seq
    import count16_pkg::*;
#(
    parameter int CW          = c_CW_DEF,
    parameter int READ_CYCLES = c_READ_CYCLES_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    count16_seq_if.slave       host,
    input  wire logic [CW-1:0] cnt_count,
    output logic      [CW-1:0] cnt_in,
    output logic               cnt_load_l,
    output logic               cnt_enable_l,
    output logic               cnt_oe_l
);
    // Window counter is loaded with READ_CYCLES-1 so that zero marks the last READ cycle.
    localparam logic [c_RDWIN_W-1:0] c_RD_LOAD = c_RDWIN_W'(READ_CYCLES - 1);

    state_t        r_state_q,  w_state_d;
    logic [CW-1:0] r_end_q,    w_end_d;
    logic [CW-1:0] r_cnt_in_q, w_cnt_in_d;
    logic [CW-1:0] r_steps_q,  w_steps_d;
    logic          r_load_l_q, w_load_l_d;
    logic          r_oe_l_q,   w_oe_l_d;
    logic          r_busy_q,   w_busy_d;
    logic          r_done_q,   w_done_d;

    logic w_accept;
    logic w_at_end;
    logic w_rd_load;
    logic w_rd_zero;

    assign w_accept  = (r_state_q == ST_IDLE) && host.start && !host.abort;
    assign w_at_end  = (cnt_count == r_end_q);
    assign w_rd_load = (r_state_q == ST_RUN) && (w_state_d == ST_READ);

    count16_seq_rdwin #(
        .WIDTH (c_RDWIN_W)
    ) u_rdwin (
        .clk      (clk),
        .rst      (rst),
        .clr      (host.abort),
        .load     (w_rd_load),
        .load_val (c_RD_LOAD),
        .dec      (r_state_q == ST_READ),
        .zero     (w_rd_zero)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_end_d    = r_end_q;
        w_cnt_in_d = r_cnt_in_q;
        w_steps_d  = r_steps_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d  = ST_LOAD;
                    w_end_d    = host.end_val;
                    w_cnt_in_d = host.start_val;
                    w_steps_d  = host.end_val - host.start_val;
                end
            end
            ST_LOAD: w_state_d = ST_RUN;
            ST_RUN:  if (w_at_end)  w_state_d = ST_READ;
            ST_READ: if (w_rd_zero) w_state_d = ST_DONE;
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase

        if (host.abort) begin
            w_state_d = ST_IDLE;
        end

        // Registered controls are decoded from the next state so they line up with it.
        w_load_l_d = (w_state_d != ST_LOAD);
        w_oe_l_d   = (w_state_d != ST_READ);
        w_busy_d   = (w_state_d != ST_IDLE);
        w_done_d   = (w_state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_end_q    <= '0;
            r_cnt_in_q <= '0;
            r_steps_q  <= '0;
            r_load_l_q <= 1'b1;
            r_oe_l_q   <= 1'b1;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_end_q    <= w_end_d;
            r_cnt_in_q <= w_cnt_in_d;
            r_steps_q  <= w_steps_d;
            r_load_l_q <= w_load_l_d;
            r_oe_l_q   <= w_oe_l_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
        end
    end

    // Combinational so counting stops on the very cycle the end value appears.
    assign cnt_enable_l = !((r_state_q == ST_RUN) && !host.pause && !host.abort && !w_at_end);

    assign cnt_in     = r_cnt_in_q;
    assign cnt_load_l = r_load_l_q;
    assign cnt_oe_l   = r_oe_l_q;
    assign host.busy  = r_busy_q;
    assign host.done  = r_done_q;
    assign host.steps = r_steps_q;

endmodule : count16_seq
`default_nettype wire

// File: tb/tb_count16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_count16_seq
// Description : Directed self-checking bench for count16_seq with a count16 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count16_seq;
    import count16_pkg::*;

    localparam int CW = 4;
    localparam int RC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    count16_seq_if #(.CW(CW)) host ();

    logic [CW-1:0] cnt_count;
    logic [CW-1:0] cnt_in;
    logic          cnt_load_l;
    logic          cnt_enable_l;
    logic          cnt_oe_l;

    count16_seq #(
        .CW          (CW),
        .READ_CYCLES (RC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (host.slave),
        .cnt_count    (cnt_count),
        .cnt_in       (cnt_in),
        .cnt_load_l   (cnt_load_l),
        .cnt_enable_l (cnt_enable_l),
        .cnt_oe_l     (cnt_oe_l)
    );

    // Behavioural count16: not reset, starts from a stale value.
    logic [CW-1:0] cnt_q = 4'd5;
    always @(posedge clk) begin
        if (!cnt_load_l)        cnt_q <= cnt_in;
        else if (!cnt_enable_l) cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_count = cnt_q;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE; cycle 0 is the cycle start is presented.
    task automatic run_txn(input string tag, input logic [CW-1:0] sv, input logic [CW-1:0] ev,
                           input int pause_at, input int pause_len, input int ign_at,
                           input int exp_lat, input int exp_steps);
        int lat = -1;
        int nld = 0, nen = 0, noe = 0, busybad = 0;
        logic [CW-1:0] first_run = '0, frz_a = '0, frz_b = '0, steps_seen = '0;
        host.start_val = sv;
        host.end_val   = ev;
        host.start     = 1'b1;
        tick();
        host.start = 1'b0;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            host.pause = (pause_len > 0) && (c >= pause_at) && (c < pause_at + pause_len);
            host.start = (c == ign_at);
            if (c == ign_at) begin
                host.start_val = 4'd0;
                host.end_val   = 4'd12;
            end
            #1;
            if (!host.busy)    busybad++;
            if (!cnt_load_l)   nld++;
            if (!cnt_enable_l) nen++;
            if (!cnt_oe_l)     noe++;
            if (c == 2)        first_run = cnt_count;
            if (c == pause_at) frz_a = cnt_count;
            if (c == pause_at + pause_len - 1) frz_b = cnt_count;
            if (host.done) begin
                lat        = c;
                steps_seen = host.steps;
            end
            tick();
        end
        host.start = 1'b0;
        host.pause = 1'b0;
        #1;
        chk({tag, " latency"},   lat,        exp_lat);
        chk({tag, " steps"},     steps_seen, exp_steps);
        chk({tag, " load_lo"},   nld,        1);
        chk({tag, " enable_lo"}, nen,        exp_steps);
        chk({tag, " oe_lo"},     noe,        RC);
        chk({tag, " busy_gap"},  busybad,    0);
        chk({tag, " first_cnt"}, first_run,  sv);
        chk({tag, " final_cnt"}, cnt_count,  ev);
        chk({tag, " busy_after"}, host.busy, 1'b0);
        chk({tag, " done_after"}, host.done, 1'b0);
        if (pause_len > 0) chk({tag, " frozen"}, frz_b, frz_a);
    endtask

    initial begin
        host.start     = 1'b0;
        host.start_val = '0;
        host.end_val   = '0;
        host.pause     = 1'b0;
        host.abort     = 1'b0;
        rst            = 1'b1;
        tick();
        tick();
        chk("rst load_l",   cnt_load_l,   1'b1);
        chk("rst enable_l", cnt_enable_l, 1'b1);
        chk("rst oe_l",     cnt_oe_l,     1'b1);
        chk("rst cnt_in",   cnt_in,       4'd0);
        chk("rst busy",     host.busy,    1'b0);
        chk("rst done",     host.done,    1'b0);
        chk("rst steps",    host.steps,   4'd0);
        rst = 1'b0;
        tick();

        // Reset while counting 0 -> 15.
        host.start_val = 4'd0;
        host.end_val   = 4'd15;
        host.start     = 1'b1;
        tick();
        host.start = 1'b0;
        tick();
        tick();
        tick();
        chk("midrun enable_lo", cnt_enable_l, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrun load_l",   cnt_load_l,   1'b1);
        chk("midrun enable_l", cnt_enable_l, 1'b1);
        chk("midrun oe_l",     cnt_oe_l,     1'b1);
        chk("midrun busy",     host.busy,    1'b0);
        chk("midrun done",     host.done,    1'b0);
        tick();

        run_txn("basic", 4'd3,  4'd7, 0, 0, 0,  9, 4);
        run_txn("wrap",  4'd14, 4'd1, 0, 0, 0,  8, 3);
        run_txn("equal", 4'd9,  4'd9, 0, 0, 0,  5, 0);
        run_txn("pause", 4'd3,  4'd7, 3, 3, 2, 12, 4);

        // Abort on the first READ cycle (cycle 7 for 3 -> 7).
        host.start_val = 4'd3;
        host.end_val   = 4'd7;
        host.start     = 1'b1;
        tick();
        host.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort in_read", cnt_oe_l, 1'b0);
        host.abort = 1'b1;
        tick();
        host.abort = 1'b0;
        chk("abort oe_l", cnt_oe_l,  1'b1);
        chk("abort busy", host.busy, 1'b0);
        chk("abort done", host.done, 1'b0);
        tick();
        chk("abort no_done", host.done, 1'b0);

        // abort together with start in IDLE: start ignored.
        host.start = 1'b1;
        host.abort = 1'b1;
        tick();
        host.start = 1'b0;
        host.abort = 1'b0;
        chk("abort_start busy", host.busy,  1'b0);
        chk("abort_start load", cnt_load_l, 1'b1);
        tick();

        run_txn("post_abort", 4'd10, 4'd12, 0, 0, 0, 7, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_count16_seq
`default_nettype wire
